// File: rtl/alu_script.sv
// alu_script: Bitcoin-script stack/arithmetic ALU between opcode sequencer and stack.
// Latches up to two popped operands, executes one opcode, pulses done or error.
module alu_script #(
    parameter int W  = 512,
    parameter int MW = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    opcode,
    input  logic          put_alu_in1,
    input  logic [W-1:0]  data_alu_in1,
    input  logic          put_alu_in2,
    input  logic [W-1:0]  data_alu_in2,
    output logic          pop_req,
    output logic          put_alu_out1,
    output logic [W-1:0]  data_alu_out1,
    output logic          put_alu_out2,
    output logic [W-1:0]  data_alu_out2,
    output logic          done,
    output logic          error,
    output logic [MW-1:0] check_sig_msg
);

    localparam logic [7:0] OP_DROP        = 8'h75;
    localparam logic [7:0] OP_DUP         = 8'h76;
    localparam logic [7:0] OP_SWAP        = 8'h7c;
    localparam logic [7:0] OP_EQUAL       = 8'h87;
    localparam logic [7:0] OP_EQUALVERIFY = 8'h88;
    localparam logic [7:0] OP_1ADD        = 8'h8b;
    localparam logic [7:0] OP_1SUB        = 8'h8c;
    localparam logic [7:0] OP_NOT         = 8'h91;
    localparam logic [7:0] OP_ADD         = 8'h93;
    localparam logic [7:0] OP_SUB         = 8'h94;
    localparam logic [7:0] OP_CHECKSIG    = 8'hac;

    typedef enum logic [1:0] {
        IDLE,
        WAIT2,
        EXEC
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [7:0]    op_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;

    logic          op_two;
    logic          start;
    logic          ld_in2;

    logic          done_d;
    logic          error_d;
    logic          put1_d;
    logic          put2_d;
    logic [W-1:0]  out1_d;
    logic [W-1:0]  out2_d;
    logic [MW-1:0] msg_d;

    logic          a_eq_b;
    logic          b_zero;

    // Only the opcodes that consume the second stack item need a pop.
    always_comb begin
        op_two = 1'b0;
        case (opcode)
            OP_SWAP,
            OP_EQUAL,
            OP_EQUALVERIFY,
            OP_ADD,
            OP_SUB:  op_two = 1'b1;
            default: op_two = 1'b0;
        endcase
    end

    assign start   = (state == IDLE) && put_alu_in1;
    assign ld_in2  = (start && put_alu_in2)
                   || ((state == WAIT2) && put_alu_in2);
    assign pop_req = (state == WAIT2);

    always_comb begin
        state_d = state;
        unique case (1'b1)
            state == IDLE: begin
                if (put_alu_in1) begin
                    state_d = (op_two && !put_alu_in2) ? WAIT2 : EXEC;
                end
            end
            state == WAIT2: begin
                if (put_alu_in2) begin
                    state_d = EXEC;
                end
            end
            state == EXEC: state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_d;
            if (start) begin
                op_q <= opcode;
                b_q  <= data_alu_in1;
            end
            if (ld_in2) begin
                a_q <= data_alu_in2;
            end
        end
    end

    assign a_eq_b = (a_q == b_q);
    assign b_zero = (b_q == '0);

    always_comb begin
        done_d  = 1'b0;
        error_d = 1'b0;
        put1_d  = 1'b0;
        put2_d  = 1'b0;
        out1_d  = '0;
        out2_d  = '0;
        msg_d   = check_sig_msg;
        if (state == EXEC) begin
            done_d = 1'b1;
            case (op_q)
                OP_DROP: ;
                OP_DUP: begin
                    put1_d = 1'b1;
                    put2_d = 1'b1;
                    out1_d = b_q;
                    out2_d = b_q;
                end
                // out2 is pushed last, so a ends on top.
                OP_SWAP: begin
                    put1_d = 1'b1;
                    put2_d = 1'b1;
                    out1_d = b_q;
                    out2_d = a_q;
                end
                OP_EQUAL: begin
                    put1_d = 1'b1;
                    out1_d = {{(W-1){1'b0}}, a_eq_b};
                end
                OP_EQUALVERIFY: begin
                    done_d  = a_eq_b;
                    error_d = !a_eq_b;
                end
                OP_1ADD: begin
                    put1_d = 1'b1;
                    out1_d = b_q + W'(1);
                end
                OP_1SUB: begin
                    put1_d = 1'b1;
                    out1_d = b_q - W'(1);
                end
                OP_NOT: begin
                    put1_d = 1'b1;
                    out1_d = {{(W-1){1'b0}}, b_zero};
                end
                OP_ADD: begin
                    put1_d = 1'b1;
                    out1_d = a_q + b_q;
                end
                OP_SUB: begin
                    put1_d = 1'b1;
                    out1_d = a_q - b_q;
                end
                OP_CHECKSIG: msg_d = b_q[MW-1:0];
                default: begin
                    done_d  = 1'b0;
                    error_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done          <= 1'b0;
            error         <= 1'b0;
            put_alu_out1  <= 1'b0;
            put_alu_out2  <= 1'b0;
            data_alu_out1 <= '0;
            data_alu_out2 <= '0;
            check_sig_msg <= '0;
        end else begin
            done          <= done_d;
            error         <= error_d;
            put_alu_out1  <= put1_d;
            put_alu_out2  <= put2_d;
            data_alu_out1 <= out1_d;
            data_alu_out2 <= out2_d;
            check_sig_msg <= msg_d;
        end
    end

endmodule

// File: tb/tb_alu_script.sv
// tb_alu_script: directed plus randomized opcode sequences for alu_script,
// checked against a behavioural model of the script opcodes.
module tb_alu_script;

    logic         clk;
    logic         rst;
    logic [7:0]   opcode;
    logic         put_alu_in1;
    logic [511:0] data_alu_in1;
    logic         put_alu_in2;
    logic [511:0] data_alu_in2;
    logic         pop_req;
    logic         put_alu_out1;
    logic [511:0] data_alu_out1;
    logic         put_alu_out2;
    logic [511:0] data_alu_out2;
    logic         done;
    logic         error;
    logic [255:0] check_sig_msg;

    int checks = 0;
    int errors = 0;
    logic [255:0] exp_msg = '0;
    logic [511:0] last_out1;
    logic [7:0] known_ops [11] = '{8'h75, 8'h76, 8'h7c, 8'h87, 8'h88, 8'h8b,
                                   8'h8c, 8'h91, 8'h93, 8'h94, 8'hac};

    alu_script dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .put_alu_in1   (put_alu_in1),
        .data_alu_in1  (data_alu_in1),
        .put_alu_in2   (put_alu_in2),
        .data_alu_in2  (data_alu_in2),
        .pop_req       (pop_req),
        .put_alu_out1  (put_alu_out1),
        .data_alu_out1 (data_alu_out1),
        .put_alu_out2  (put_alu_out2),
        .data_alu_out2 (data_alu_out2),
        .done          (done),
        .error         (error),
        .check_sig_msg (check_sig_msg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_w();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit is_two(input logic [7:0] op);
        return op == 8'h7c || op == 8'h87 || op == 8'h88
            || op == 8'h93 || op == 8'h94;
    endfunction

    // Stack-machine semantics: a = second item, b = top; results mod 2^512.
    function automatic void model(input logic [7:0] op,
                                  input logic [511:0] a, input logic [511:0] b,
                                  output bit ok, output bit p1, output bit p2,
                                  output logic [511:0] r1,
                                  output logic [511:0] r2);
        ok = 1; p1 = 0; p2 = 0; r1 = '0; r2 = '0;
        case (op)
            8'h75: ;
            8'h76: begin p1 = 1; p2 = 1; r1 = b; r2 = b; end
            8'h7c: begin p1 = 1; p2 = 1; r1 = b; r2 = a; end
            8'h87: begin p1 = 1; r1 = (a == b) ? 512'd1 : 512'd0; end
            8'h88: ok = (a == b);
            8'h8b: begin p1 = 1; r1 = b + 512'd1; end
            8'h8c: begin p1 = 1; r1 = b - 512'd1; end
            8'h91: begin p1 = 1; r1 = (b == 0) ? 512'd1 : 512'd0; end
            8'h93: begin p1 = 1; r1 = a + b; end
            8'h94: begin p1 = 1; r1 = a - b; end
            8'hac: ;
            default: ok = 0;
        endcase
    endfunction

    task automatic do_op(input logic [7:0] op, input logic [511:0] a,
                         input logic [511:0] b, input bit upfront,
                         input int waits);
        bit ok, p1, p2;
        logic [511:0] r1, r2;
        model(op, a, b, ok, p1, p2, r1, r2);
        if (ok && op == 8'hac) exp_msg = b[255:0];
        opcode = op;
        put_alu_in1 = 1; data_alu_in1 = b;
        put_alu_in2 = upfront; data_alu_in2 = upfront ? a : '0;
        @(posedge clk); #1;
        put_alu_in1 = 0; put_alu_in2 = 0; opcode = 8'h00;
        data_alu_in1 = '0; data_alu_in2 = '0;
        if (is_two(op) && !upfront) begin
            for (int i = 0; i < waits; i++) begin
                chk("pop_req_wait", pop_req, 1);
                put_alu_in1 = 1; opcode = 8'h76; data_alu_in1 = rand_w();
                @(posedge clk); #1;
            end
            put_alu_in1 = 0; data_alu_in1 = '0;
            chk("pop_req_last", pop_req, 1);
            put_alu_in2 = 1; data_alu_in2 = a;
            @(posedge clk); #1;
            put_alu_in2 = 0; data_alu_in2 = '0;
        end
        chk("exec_done", done, 0);
        chk("exec_error", error, 0);
        chk("exec_pop", pop_req, 0);
        put_alu_in1 = 1; opcode = 8'h93; data_alu_in1 = rand_w();
        put_alu_in2 = 1; data_alu_in2 = rand_w();
        @(posedge clk); #1;
        put_alu_in1 = 0; put_alu_in2 = 0; opcode = 8'h00;
        data_alu_in1 = '0; data_alu_in2 = '0;
        last_out1 = data_alu_out1;
        chk("done", done, ok);
        chk("error", error, !ok);
        chk("put_out1", put_alu_out1, p1);
        chk("put_out2", put_alu_out2, p2);
        if (p1) chk("data_out1", data_alu_out1, r1);
        if (p2) chk("data_out2", data_alu_out2, r2);
        chk("check_sig_msg", check_sig_msg, exp_msg);
        @(posedge clk); #1;
        chk("post_done", done, 0);
        chk("post_error", error, 0);
        chk("post_put1", put_alu_out1, 0);
        chk("post_data1", data_alu_out1, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pop"}, pop_req, 0);
        chk({tag, "_put1"}, put_alu_out1, 0);
        chk({tag, "_put2"}, put_alu_out2, 0);
        chk({tag, "_out1"}, data_alu_out1, 0);
        chk({tag, "_out2"}, data_alu_out2, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_msg"}, check_sig_msg, 0);
    endtask

    initial begin
        logic [511:0] a, b;
        logic [7:0] op;
        int sel;
        rst = 0; opcode = 0;
        put_alu_in1 = 0; data_alu_in1 = '0;
        put_alu_in2 = 0; data_alu_in2 = '0;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        #2 rst = 1;
        @(posedge clk); #1;

        do_op(8'h76, 512'd0, 512'hDEADBEEF, 1, 0);
        do_op(8'h93, 512'd7, 512'd5, 0, 3);
        chk("add_5_7", last_out1, 512'd12);
        do_op(8'h94, 512'd3, 512'd5, 1, 0);
        chk("sub_3_5", last_out1, {{504{1'b1}}, 8'hFE});
        do_op(8'h8b, 512'd0, {512{1'b1}}, 1, 0);
        chk("1add_wrap", last_out1, 512'd0);
        do_op(8'h88, 512'h11, 512'h11, 1, 0);
        do_op(8'h88, 512'h11, 512'h12, 0, 1);
        do_op(8'hFF, 512'd0, 512'd9, 1, 0);
        do_op(8'hac, 512'd0, 512'hABC, 0, 0);
        chk("checksig_abc", check_sig_msg, 256'hABC);
        do_op(8'h7c, 512'h22, 512'h33, 0, 0);
        do_op(8'h91, 512'd0, 512'd0, 0, 0);
        do_op(8'h8c, 512'd0, 512'd0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                             : known_ops[$urandom_range(0, 10)];
            a = rand_w(); b = rand_w();
            sel = $urandom_range(0, 3);
            if (sel == 1) a = b;
            if (sel == 2) b = {512{1'b1}};
            if (sel == 3) begin
                a = 512'($urandom_range(0, 3));
                b = 512'($urandom_range(0, 3));
            end
            do_op(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Async reset in the done cycle clears outputs immediately.
        opcode = 8'h76; put_alu_in1 = 1; data_alu_in1 = 512'h55;
        @(posedge clk); #1;
        put_alu_in1 = 0; data_alu_in1 = '0;
        @(posedge clk); #1;
        chk("pre_rst_done", done, 1);
        #1 rst = 0;
        #1 chk_all_zero("rst_done_cycle");
        exp_msg = '0;
        #1 rst = 1;
        @(posedge clk); #1;

        // Async reset while waiting for operand 2 aborts the op.
        opcode = 8'h93; put_alu_in1 = 1; data_alu_in1 = 512'd1;
        @(posedge clk); #1;
        put_alu_in1 = 0; data_alu_in1 = '0;
        chk("abort_pop", pop_req, 1);
        #1 rst = 0;
        #1 chk_all_zero("rst_wait2");
        #1 rst = 1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
            chk("abort_no_error", error, 0);
            chk("abort_idle_pop", pop_req, 0);
        end
        do_op(8'h93, 512'd2, 512'd40, 1, 0);
        chk("after_abort_add", last_out1, 512'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
